// File: rtl/colour_pattern_pkg.sv
// -----------------------------------------------------------------------------
// colour_pattern_pkg
// Shared types and constants for the VGA test-pattern generator:
//   - pattern_mode_t : run-time selectable pattern
//   - BAR_COLOURS    : colour-bar table as 3-bit {r,g,b} on/off masks
//   - BG_R/BG_G/BG_B : background colour, LSB-aligned channel values
// -----------------------------------------------------------------------------
package colour_pattern_pkg;

   typedef enum logic [1:0] {
      PAT_SQUARE = 2'd0,
      PAT_BARS   = 2'd1,
      PAT_GRAD   = 2'd2,
      PAT_CHECK  = 2'd3
   } pattern_mode_t;

   // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [0:7][2:0] BAR_COLOURS = {
      3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
   };

   localparam int unsigned BG_R = 0;
   localparam int unsigned BG_G = 1;
   localparam int unsigned BG_B = 3;

endpackage

// File: rtl/colour_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// colour_pattern_gen_if
// Pixel bus between the display timing block and the VGA output stage.
//   sx, sy       : current pixel coordinates (CORDW bits)
//   de           : data enable, high in the active area
//   hsync, vsync : sync from the timing block, active low
//   vga_hsync/vga_vsync : sync delayed to line up with RGB
//   vga_r/g/b    : pixel colour (CHANW bits per channel)
// Modports: master = timing side (drives coordinates), slave = generator.
// -----------------------------------------------------------------------------
interface colour_pattern_gen_if #(
   parameter int CORDW = 10,
   parameter int CHANW = 4
);
   logic [CORDW-1:0] sx;
   logic [CORDW-1:0] sy;
   logic             de;
   logic             hsync;
   logic             vsync;
   logic             vga_hsync;
   logic             vga_vsync;
   logic [CHANW-1:0] vga_r;
   logic [CHANW-1:0] vga_g;
   logic [CHANW-1:0] vga_b;

   modport master (
      output sx, sy, de, hsync, vsync,
      input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b
   );

   modport slave (
      input  sx, sy, de, hsync, vsync,
      output vga_hsync, vga_vsync, vga_r, vga_g, vga_b
   );
endinterface

// File: rtl/colour_bar_lut.sv
// -----------------------------------------------------------------------------
// colour_bar_lut
// Combinational map from colour-bar index to full-scale RGB.
//   bar_idx : bar number 0..7
//   r, g, b : CHANW-bit channels, each either all ones or zero
// -----------------------------------------------------------------------------
module colour_bar_lut
   import colour_pattern_pkg::*;
#(
   parameter int CHANW = 4
) (
   input  logic [2:0]       bar_idx,
   output logic [CHANW-1:0] r,
   output logic [CHANW-1:0] g,
   output logic [CHANW-1:0] b
);
   logic [2:0] mask;

   assign mask = BAR_COLOURS[bar_idx];
   assign r    = {CHANW{mask[2]}};
   assign g    = {CHANW{mask[1]}};
   assign b    = {CHANW{mask[0]}};
endmodule

// File: rtl/colour_pattern_gen.sv
// -----------------------------------------------------------------------------
// colour_pattern_gen
// Multi-mode VGA test-pattern generator with a 2-cycle pixel pipeline.
// Ports:
//   clk_pix   : pixel clock
//   rst_pix_n : asynchronous active-low reset
//   mode      : requested pattern (0 square, 1 bars, 2 gradient, 3 checker),
//               taken only at the start of vertical blanking
//   bus       : colour_pattern_gen_if.slave (coordinates/sync in, RGB/sync out)
//   frame_cnt : frames completed since reset, wraps silently
// Build option: define PATTERN_ANIM_EN to scroll the checkerboard one pixel
// per frame; otherwise the checkerboard is static.
// -----------------------------------------------------------------------------
module colour_pattern_gen
   import colour_pattern_pkg::*;
#(
   parameter int CORDW    = 10,
   parameter int CHANW    = 4,
   parameter int H_RES    = 640,
   parameter int V_RES    = 480,
   parameter int SQ_LOG2  = 8,
   parameter int BARS     = 8,
   parameter int CHK_LOG2 = 5,
   parameter int FRAMEW   = 8
) (
   input  logic                clk_pix,
   input  logic                rst_pix_n,
   input  logic [1:0]          mode,
   colour_pattern_gen_if.slave bus,
   output logic [FRAMEW-1:0]   frame_cnt
);
   localparam int BAR_W = H_RES / BARS;

   // Square blue is 0100 scaled to the channel width: only bit CHANW-2 set.
   localparam logic [CHANW-1:0] SQ_BLUE =
      (CHANW >= 2) ? (CHANW'(1) << (CHANW >= 2 ? CHANW - 2 : 0)) : '0;
   localparam logic [CHANW-1:0] BGC_R = CHANW'(BG_R);
   localparam logic [CHANW-1:0] BGC_G = CHANW'(BG_G);
   localparam logic [CHANW-1:0] BGC_B = CHANW'(BG_B);

   logic             fe;
   pattern_mode_t    mode_q;
   logic [CORDW-1:0] offset;
   logic [CORDW-1:0] xo;

   // Bar counters; bar_idx doubles as the stage-1 bar index register.
   logic [CORDW-1:0] bar_px;
   logic [2:0]       bar_idx;

   // Stage 1
   logic             de_s1, hs_s1, vs_s1, sq_in_s1, chk_s1;
   pattern_mode_t    mode_s1;
   logic [CHANW-1:0] sq_r_s1, sq_g_s1, gr_r_s1, gr_g_s1;

   // Stage 2
   logic [CHANW-1:0] bar_r, bar_g, bar_b;
   logic [CHANW-1:0] r_d, g_d, b_d;
   logic [CHANW-1:0] r_q, g_q, b_q;
   logic             hs_q, vs_q;

   // Start of vertical blanking: the only point where the mode may change.
   assign fe = (bus.sx == '0) && (bus.sy == CORDW'(V_RES));

`ifdef PATTERN_ANIM_EN
   assign offset = CORDW'(frame_cnt);
`else
   assign offset = '0;
`endif

   assign xo = bus.sx + offset;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         mode_q    <= PAT_SQUARE;
         frame_cnt <= '0;
      end else if (fe) begin
         mode_q    <= pattern_mode_t'(mode);
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // After the edge of pixel sx the counters hold that pixel's bar position,
   // so sx==0 clears rather than advances.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (bus.sx == '0) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (bus.de) begin
         if (bar_px == CORDW'(BAR_W - 1)) begin
            bar_px <= '0;
            if (bar_idx != 3'(BARS - 1)) bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_px <= bar_px + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         de_s1    <= 1'b0;
         hs_s1    <= 1'b1;
         vs_s1    <= 1'b1;
         sq_in_s1 <= 1'b0;
         chk_s1   <= 1'b0;
         mode_s1  <= PAT_SQUARE;
         sq_r_s1  <= '0;
         sq_g_s1  <= '0;
         gr_r_s1  <= '0;
         gr_g_s1  <= '0;
      end else begin
         de_s1    <= bus.de;
         hs_s1    <= bus.hsync;
         vs_s1    <= bus.vsync;
         sq_in_s1 <= ((bus.sx >> SQ_LOG2) == '0) && ((bus.sy >> SQ_LOG2) == '0);
         chk_s1   <= xo[CHK_LOG2] ^ bus.sy[CHK_LOG2];
         mode_s1  <= mode_q;
         sq_r_s1  <= bus.sx[SQ_LOG2-1 -: CHANW];
         sq_g_s1  <= bus.sy[SQ_LOG2-1 -: CHANW];
         gr_r_s1  <= bus.sx[CORDW-1 -: CHANW];
         gr_g_s1  <= bus.sy[CORDW-1 -: CHANW];
      end
   end

   colour_bar_lut #(.CHANW(CHANW)) u_bar_lut (
      .bar_idx (bar_idx),
      .r       (bar_r),
      .g       (bar_g),
      .b       (bar_b)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch; the default is also the blank.
   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (de_s1) begin
         unique case (mode_s1)
            PAT_SQUARE: begin
               if (sq_in_s1) begin
                  r_d = sq_r_s1;
                  g_d = sq_g_s1;
                  b_d = SQ_BLUE;
               end else begin
                  r_d = BGC_R;
                  g_d = BGC_G;
                  b_d = BGC_B;
               end
            end
            PAT_BARS: begin
               r_d = bar_r;
               g_d = bar_g;
               b_d = bar_b;
            end
            PAT_GRAD: begin
               r_d = gr_r_s1;
               g_d = gr_g_s1;
               b_d = gr_r_s1 ^ gr_g_s1;
            end
            PAT_CHECK: begin
               if (chk_s1) begin
                  r_d = '1;
                  g_d = '1;
                  b_d = '1;
               end else begin
                  r_d = BGC_R;
                  g_d = BGC_G;
                  b_d = BGC_B;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         r_q  <= '0;
         g_q  <= '0;
         b_q  <= '0;
         hs_q <= 1'b1;
         vs_q <= 1'b1;
      end else begin
         r_q  <= r_d;
         g_q  <= g_d;
         b_q  <= b_d;
         hs_q <= hs_s1;
         vs_q <= vs_s1;
      end
   end

   assign bus.vga_r     = r_q;
   assign bus.vga_g     = g_q;
   assign bus.vga_b     = b_q;
   assign bus.vga_hsync = hs_q;
   assign bus.vga_vsync = vs_q;

endmodule

// File: tb/tb_colour_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_colour_pattern_gen
// Self-checking bench for colour_pattern_gen. Two instances share stimulus:
// dut (FRAMEW=8) for the pattern checks and dut_w (FRAMEW=2) for the frame
// counter wrap. Every driven pixel pushes its expected {rgb, hsync, vsync}
// into a queue that is popped two cycles later, so pipeline alignment of
// colour and sync is checked on every marked pixel.
// -----------------------------------------------------------------------------
module tb_colour_pattern_gen;
   import colour_pattern_pkg::*;

   localparam int V_RES = 480;

   logic       clk_pix = 1'b0;
   logic       rst_pix_n;
   logic [1:0] mode;
   logic [7:0] frame_cnt;
   logic [1:0] frame_cnt_w;

   colour_pattern_gen_if #(.CORDW(10), .CHANW(4)) bus   ();
   colour_pattern_gen_if #(.CORDW(10), .CHANW(4)) bus_w ();

   colour_pattern_gen #(.FRAMEW(8)) dut (
      .clk_pix   (clk_pix),
      .rst_pix_n (rst_pix_n),
      .mode      (mode),
      .bus       (bus.slave),
      .frame_cnt (frame_cnt)
   );

   colour_pattern_gen #(.FRAMEW(2)) dut_w (
      .clk_pix   (clk_pix),
      .rst_pix_n (rst_pix_n),
      .mode      (mode),
      .bus       (bus_w.slave),
      .frame_cnt (frame_cnt_w)
   );

   always #5 clk_pix = ~clk_pix;

   typedef struct packed {
      logic            chk;
      logic [11:0]     rgb;
      logic            hs;
      logic            vs;
      logic [8*12-1:0] name;
   } exp_t;

   typedef struct packed {
      logic [1:0]      mode;
      logic [9:0]      sx;
      logic [9:0]      sy;
      logic            de;
      logic [11:0]     rgb;
      logic [8*12-1:0] name;
   } vec_t;

   exp_t       sbq[$];
   vec_t       tab[10];
   int         checks   = 0;
   int         failures = 0;
   int         fe_count = 0;
   logic [1:0] mode_drv = 2'd0;

   task automatic check(input logic [8*12-1:0] name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %0s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One pixel per call: compare the output due now, then drive the next.
   task automatic step(input logic [9:0] x, input logic [9:0] y, input logic d,
                       input logic hs, input logic vs, input logic chk,
                       input logic [11:0] rgb, input logic [8*12-1:0] name);
      exp_t e;
      @(negedge clk_pix);
      if (sbq.size() >= 2) begin
         e = sbq.pop_front();
         if (e.chk)
            check(e.name,
                  32'({bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hsync, bus.vga_vsync}),
                  32'({e.rgb, e.hs, e.vs}));
      end
      bus.sx = x;  bus.sy = y;  bus.de = d;  bus.hsync = hs;  bus.vsync = vs;
      bus_w.sx = x; bus_w.sy = y; bus_w.de = d; bus_w.hsync = hs; bus_w.vsync = vs;
      mode = mode_drv;
      e.chk = chk; e.rgb = rgb; e.hs = hs; e.vs = vs; e.name = name;
      sbq.push_back(e);
   endtask

   task automatic px(input int x, input int y, input logic d, input logic chk,
                     input logic [11:0] rgb, input logic [8*12-1:0] name);
      step(10'(x), 10'(y), d, 1'b1, 1'b1, chk, rgb, name);
   endtask

   task automatic frame_strobe(input logic [1:0] m);
      mode_drv = m;
      step(10'd0, 10'(V_RES), 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, "fe_blank");
      fe_count++;
   endtask

   function automatic logic [11:0] bar_exp(input int b);
      case (b)
         0: return 12'hFFF;
         1: return 12'hFF0;
         2: return 12'h0FF;
         3: return 12'h0F0;
         4: return 12'hF0F;
         5: return 12'hF00;
         6: return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   function automatic logic [11:0] chk_exp(input int x, input int y);
      logic [9:0] off;
      logic [9:0] xo;
      logic [9:0] yv;
`ifdef PATTERN_ANIM_EN
      off = 10'(fe_count % 256);
`else
      off = 10'd0;
`endif
      xo = 10'(x) + off;
      yv = 10'(y);
      return (xo[5] ^ yv[5]) ? 12'hFFF : 12'h013;
   endfunction

   initial begin
      logic [7:0] hpat;
      logic [7:0] vpat;
      hpat = 8'b1100_1010;
      vpat = 8'b1011_0001;

      tab[0] = '{2'd0, 10'd32,  10'd48,  1'b1, 12'h234, "sq_32_48"};
      tab[1] = '{2'd0, 10'd255, 10'd255, 1'b1, 12'hFF4, "sq_255_255"};
      tab[2] = '{2'd0, 10'd256, 10'd10,  1'b1, 12'h013, "sq_out_x"};
      tab[3] = '{2'd0, 10'd10,  10'd256, 1'b1, 12'h013, "sq_out_y"};
      tab[4] = '{2'd0, 10'd0,   10'd0,   1'b1, 12'h004, "sq_0_0"};
      tab[5] = '{2'd0, 10'd100, 10'd100, 1'b0, 12'h000, "sq_blank"};
      tab[6] = '{2'd2, 10'd639, 10'd479, 1'b1, 12'h97E, "grad_639_479"};
      tab[7] = '{2'd2, 10'd0,   10'd0,   1'b1, 12'h000, "grad_0_0"};
      tab[8] = '{2'd2, 10'd320, 10'd240, 1'b1, 12'h536, "grad_320_240"};
      tab[9] = '{2'd2, 10'd700, 10'd10,  1'b0, 12'h000, "grad_blank"};

      // Reset held mid-line.
      rst_pix_n = 1'b1;
      mode = 2'd0;
      bus.sx = 10'd300; bus.sy = 10'd100; bus.de = 1'b1; bus.hsync = 1'b1; bus.vsync = 1'b1;
      bus_w.sx = 10'd300; bus_w.sy = 10'd100; bus_w.de = 1'b1; bus_w.hsync = 1'b1; bus_w.vsync = 1'b1;
      #2 rst_pix_n = 1'b0;
      repeat (3) @(negedge clk_pix);
      check("reset_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0);
      check("reset_sync", 32'({bus.vga_hsync, bus.vga_vsync}), 32'h3);
      check("reset_fcnt", 32'(frame_cnt), 32'h0);
      rst_pix_n = 1'b1;

      // Table: square and gradient, switching mode through a frame strobe.
      for (int i = 0; i < 10; i++) begin
         if (tab[i].mode != mode_drv) frame_strobe(tab[i].mode);
         step(tab[i].sx, tab[i].sy, tab[i].de, 1'b1, 1'b1, 1'b1, tab[i].rgb, tab[i].name);
      end

      // Mid-frame mode request must not take effect until the frame strobe.
      frame_strobe(2'd0);
      mode_drv = 2'd1;
      px(100, 200, 1'b1, 1'b1, 12'h6C4, "midsw_100");
      px(101, 200, 1'b1, 1'b1, 12'h6C4, "midsw_101");
      px(300, 200, 1'b1, 1'b1, 12'h013, "midsw_300");
      frame_strobe(2'd1);

      // Full bar line; sx==0 arrives with de high.
      for (int x = 0; x < 640; x++) begin
         logic c;
         c = (x == 0) || (x == 79) || (x == 80) || (x == 160) || (x == 400) || (x == 639);
         px(x, 0, 1'b1, c, bar_exp(x / 80), "bar_line");
      end
      px(640, 0, 1'b0, 1'b1, 12'h000, "bar_blank");

      // Checkerboard, offset depends on the build option.
      frame_strobe(2'd3);
      px(29, 0,  1'b1, 1'b1, chk_exp(29, 0),  "chk_29_0");
      px(32, 0,  1'b1, 1'b1, chk_exp(32, 0),  "chk_32_0");
      px(0,  32, 1'b1, 1'b1, chk_exp(0, 32),  "chk_0_32");
      px(40, 40, 1'b1, 1'b1, chk_exp(40, 40), "chk_40_40");
      check("fcnt_mid", 32'(frame_cnt), 32'(fe_count % 256));

      // Sync delay: toggling patterns, compared exactly two cycles later.
      for (int i = 0; i < 8; i++)
         step(10'(700 + i), 10'd10, 1'b0, hpat[i], vpat[i], 1'b1, 12'h000, "sync_lat");

      // Reset mid-frame, then mode_q=0 until the first strobe.
      px(32, 48, 1'b1, 1'b0, 12'h000, "pre_rst");
      @(negedge clk_pix);
      rst_pix_n = 1'b0;
      #1;
      check("rst_mid_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0);
      check("rst_mid_sync", 32'({bus.vga_hsync, bus.vga_vsync}), 32'h3);
      check("rst_mid_fcnt", 32'(frame_cnt), 32'h0);
      check("rst_mid_fw", 32'(frame_cnt_w), 32'h0);
      sbq.delete();
      fe_count = 0;
      @(negedge clk_pix);
      rst_pix_n = 1'b1;
      mode_drv = 2'd3;
      px(32, 48, 1'b1, 1'b1, 12'h234, "post_rst_sq");

      // Frame counter wrap on the 2-bit instance.
      for (int i = 0; i < 5; i++) begin
         frame_strobe(2'd3);
         px(5, V_RES + 1, 1'b0, 1'b1, 12'h000, "vblank");
         check("fcnt", 32'(frame_cnt), 32'(fe_count % 256));
         check("fcnt_w", 32'(frame_cnt_w), 32'(fe_count % 4));
      end

      px(0, 0, 1'b0, 1'b0, 12'h000, "flush");
      px(0, 0, 1'b0, 1'b0, 12'h000, "flush");
      px(0, 0, 1'b0, 1'b0, 12'h000, "flush");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
